// File: rtl/util_cpack2_timestamp_pkg.sv
// util_cpack2_timestamp_pkg: shared widths and the FIFO write-kind encoding
package util_cpack2_timestamp_pkg;
  localparam int TS_WIDTH = 64;
  localparam int DATA_WIDTH = 64;
  typedef enum logic [1:0] {NONE, SINGLE, PAIR} wr_kind_e;
endpackage

// File: rtl/util_cpack2_timestamp_if.sv
// util_cpack2_timestamp_if: output stream to the DMA (m_axis_valid/ready/data)
interface util_cpack2_timestamp_if;
  import util_cpack2_timestamp_pkg::*;
  logic m_axis_valid;
  logic m_axis_ready;
  logic [DATA_WIDTH-1:0] m_axis_data;
  modport master(output m_axis_valid, output m_axis_data, input m_axis_ready);
  modport slave(input m_axis_valid, input m_axis_data, output m_axis_ready);
endinterface

// File: rtl/util_cpack2_timestamp_fifo.sv
// util_cpack2_timestamp_fifo: FWFT buffer writing one or two words per cycle
// Ports: clk/rst, flush (empties), wr_kind + wr_data0/1 (write, data0 first),
// rd_en (pop), rd_valid/rd_data (head word, 0 when empty), full, free (space).
module util_cpack2_timestamp_fifo
  import util_cpack2_timestamp_pkg::*;
#(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  wr_kind_e              wr_kind,
  input  logic [DATA_WIDTH-1:0] wr_data0,
  input  logic [DATA_WIDTH-1:0] wr_data1,
  input  logic                  rd_en,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic [AW:0]           free
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic empty;
  always_comb begin
    count = wr_ptr - rd_ptr;
    free = (AW+1)'(DEPTH) - count;
    empty = wr_ptr == rd_ptr;
    full = count == (AW+1)'(DEPTH);
    rd_valid = !empty;
    rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_kind != NONE) wr_ptr <= wr_ptr + (wr_kind == PAIR ? (AW+1)'(2) : (AW+1)'(1));
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (!flush && wr_kind != NONE) begin
      mem[wr_ptr[AW-1:0]] <= wr_data0;
      if (wr_kind == PAIR) mem[wr_ptr[AW-1:0] + AW'(1)] <= wr_data1;
    end
  end
endmodule

// File: rtl/util_cpack2_timestamp.sv
// util_cpack2_timestamp: inserts a timestamp word before each block of ADC words
// Ports: adc_clk, reset (async, active-high), timestamp, timestamp_every
// (0 = no insertion), dma_xfer_req, fifo_wr_en/fifo_wr_data (no backpressure),
// fifo_wr_overflow (pulse per dropped write), m_axis (master stream).
// Option UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN adds drop_count (saturating drops).
module util_cpack2_timestamp
  import util_cpack2_timestamp_pkg::*;
#(
  parameter int NUM_OF_CHANNELS = 4,
  parameter int SAMPLE_DATA_WIDTH = 16,
  parameter int SAMPLES_PER_CHANNEL = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          adc_clk,
  input  logic          reset,
  input  logic [TS_WIDTH-1:0] timestamp,
  input  logic [31:0]   timestamp_every,
  input  logic          dma_xfer_req,
  input  logic          fifo_wr_en,
  input  logic [NUM_OF_CHANNELS*SAMPLE_DATA_WIDTH*SAMPLES_PER_CHANNEL-1:0] fifo_wr_data,
  output logic          fifo_wr_overflow,
  util_cpack2_timestamp_if.master m_axis
`ifdef UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN
  , output logic [31:0] drop_count
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [31:0] cnt, every_q;
  logic [DATA_WIDTH-1:0] word;
  logic full, rd, ok, drop;
  logic [AW:0] free, free_after;
  wr_kind_e kind, push;
  assign word = fifo_wr_data;
  always_comb begin
    rd = m_axis.m_axis_valid && m_axis.m_axis_ready;
    kind = !(fifo_wr_en && dma_xfer_req) ? NONE : (cnt == '0 && timestamp_every != '0) ? PAIR : SINGLE;
    // space freed by this cycle's read is usable by this cycle's write
    free_after = free + {{AW{1'b0}}, rd};
    ok = kind == PAIR ? free_after >= (AW+1)'(2) : (!full || rd);
    push = ok ? kind : NONE;
    drop = kind != NONE && !ok;
  end
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      every_q <= '0;
      fifo_wr_overflow <= 1'b0;
    end else begin
      fifo_wr_overflow <= drop;
      // a drop restarts the block so the next timestamp matches its data
      if (!dma_xfer_req || drop) cnt <= '0;
      else if (push != NONE) begin
        if (cnt == '0) begin
          every_q <= timestamp_every;
          cnt <= timestamp_every > 32'd1 ? 32'd1 : 32'd0;
        end else cnt <= (cnt + 32'd1 == every_q) ? '0 : cnt + 32'd1;
      end
    end
  end
  util_cpack2_timestamp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(adc_clk),
    .rst(reset),
    .flush(!dma_xfer_req),
    .wr_kind(push),
    .wr_data0(push == PAIR ? timestamp : word),
    .wr_data1(word),
    .rd_en(m_axis.m_axis_ready),
    .rd_valid(m_axis.m_axis_valid),
    .rd_data(m_axis.m_axis_data),
    .full(full),
    .free(free)
  );
`ifdef UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN
  logic dma_q;
  always_ff @(posedge adc_clk or posedge reset) begin
    if (reset) begin
      dma_q <= 1'b0;
      drop_count <= '0;
    end else begin
      dma_q <= dma_xfer_req;
      if (dma_xfer_req && !dma_q) drop_count <= '0;
      else if (drop && drop_count != '1) drop_count <= drop_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_util_cpack2_timestamp.sv
// tb_util_cpack2_timestamp: table vectors plus drop/flush/reset sequences, scoreboarded
module tb_util_cpack2_timestamp;
  import util_cpack2_timestamp_pkg::*;
  logic clk = 1'b0, rst = 1'b1, dma = 1'b0, wr_en = 1'b0, ovf;
  logic [63:0] ts = '0, wd = '0;
  logic [31:0] every = '0;
  util_cpack2_timestamp_if axis();
`ifdef UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN
  logic [31:0] drop_count;
`endif
  util_cpack2_timestamp #(.FIFO_DEPTH(8)) dut (
    .adc_clk(clk),
    .reset(rst),
    .timestamp(ts),
    .timestamp_every(every),
    .dma_xfer_req(dma),
    .fifo_wr_en(wr_en),
    .fifo_wr_data(wd),
    .fifo_wr_overflow(ovf),
    .m_axis(axis)
`ifdef UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN
    , .drop_count(drop_count)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] every;
    logic [63:0] data;
    logic [63:0] ts;
    bit ins;
  } vec_t;
  vec_t tbl[21];
  logic [63:0] q[$];
  int n_cmp = 0, n_bad = 0, n_ovf = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && ovf) n_ovf++;
    if (!rst && axis.m_axis_valid && axis.m_axis_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_word: got %0d expected no word", axis.m_axis_data);
      end else check("stream", axis.m_axis_data, q.pop_front());
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(logic [63:0] d, logic [63:0] t);
    wr_en = 1'b1;
    wd = d;
    ts = t;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic drain(string nm);
    int k = 0;
    axis.m_axis_ready = 1'b1;
    while (q.size() != 0 && k < 200) begin
      tick();
      k++;
    end
    check({nm, "_left"}, 64'(q.size()), 0);
    tick();
    check({nm, "_idle"}, 64'(axis.m_axis_valid), 0);
  endtask
  task automatic restart(logic [31:0] e);
    axis.m_axis_ready = 1'b0;
    every = e;
    dma = 1'b0;
    tick();
    dma = 1'b1;
  endtask
  task automatic drop_seq(int e, int n);
    int occ = 0, c = 0, drops = 0, ovf0;
    logic [63:0] d, t;
    restart(32'(e));
    ovf0 = n_ovf;
    for (int i = 0; i < n; i++) begin
      d = 64'(e * 100 + i + 1);
      t = 64'(e * 1000 + i);
      if (occ + (c == 0 ? 2 : 1) <= 8) begin
        if (c == 0) q.push_back(t);
        q.push_back(d);
        occ += c == 0 ? 2 : 1;
        c = (c + 1 == e) ? 0 : c + 1;
      end else begin
        drops++;
        c = 0;
      end
      wr(d, t);
    end
    tick();
    tick();
    check($sformatf("ovf_pulses_e%0d", e), 64'(n_ovf - ovf0), 64'(drops));
`ifdef UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN
    check($sformatf("drop_count_e%0d", e), drop_count, 64'(drops));
`endif
    check("hold_valid", 64'(axis.m_axis_valid), 1);
    check("hold_data", axis.m_axis_data, q[0]);
    tick();
    check("hold_data2", axis.m_axis_data, q[0]);
    drain("drop");
    q.push_back(64'(e * 1000 + 77));
    q.push_back(64'(e * 100 + 77));
    wr(64'(e * 100 + 77), 64'(e * 1000 + 77));
    drain("fresh");
  endtask
  initial begin
    for (int i = 0; i < 8; i++) tbl[i] = '{32'd0, 64'(i + 1), 64'(1000 + i), 1'b0};
    for (int i = 0; i < 8; i++) tbl[8 + i] = '{32'd4, 64'(2001 + i), 64'(100 + i), (i % 4) == 0};
    tbl[16] = '{32'd3, 64'd3001, 64'd300, 1'b1};
    tbl[17] = '{32'd1, 64'd3002, 64'd301, 1'b0};
    tbl[18] = '{32'd1, 64'd3003, 64'd302, 1'b0};
    tbl[19] = '{32'd1, 64'd3004, 64'd303, 1'b1};
    tbl[20] = '{32'd1, 64'd3005, 64'd304, 1'b1};
    axis.m_axis_ready = 1'b0;
    repeat (3) tick();
    check("rst_valid", 64'(axis.m_axis_valid), 0);
    check("rst_data", axis.m_axis_data, 0);
    check("rst_ovf", 64'(ovf), 0);
    rst = 1'b0;
    dma = 1'b1;
    axis.m_axis_ready = 1'b1;
    tick();
    foreach (tbl[i]) begin
      every = tbl[i].every;
      if (tbl[i].ins) q.push_back(tbl[i].ts);
      q.push_back(tbl[i].data);
      wr(tbl[i].data, tbl[i].ts);
    end
    drain("table");
    check("table_no_ovf", 64'(n_ovf), 0);
    drop_seq(4, 7);
    drop_seq(6, 7);
    drop_seq(4, 10);
    dma = 1'b0;
    tick();
    dma = 1'b1;
    tick();
`ifdef UTIL_CPACK2_TIMESTAMP_DROP_CNT_EN
    check("drop_count_clear", drop_count, 0);
`endif
    restart(32'd4);
    wr(64'd4001, 64'd400);
    wr(64'd4002, 64'd401);
    check("pre_flush_valid", 64'(axis.m_axis_valid), 1);
    dma = 1'b0;
    tick();
    check("flush_valid", 64'(axis.m_axis_valid), 0);
    wr(64'd4009, 64'd999);
    check("idle_ignored", 64'(axis.m_axis_valid), 0);
    dma = 1'b1;
    axis.m_axis_ready = 1'b1;
    q.push_back(64'd402);
    q.push_back(64'd4003);
    wr(64'd4003, 64'd402);
    drain("flush");
    restart(32'd8);
    for (int i = 0; i < 4; i++) wr(64'(5001 + i), 64'(600 + i));
    check("pre_rst_valid", 64'(axis.m_axis_valid), 1);
    rst = 1'b1;
    tick();
    check("mid_rst_valid", 64'(axis.m_axis_valid), 0);
    check("mid_rst_data", axis.m_axis_data, 0);
    rst = 1'b0;
    axis.m_axis_ready = 1'b1;
    q.push_back(64'd800);
    q.push_back(64'd5101);
    wr(64'd5101, 64'd800);
    drain("post_rst");
    check("total_ovf", 64'(n_ovf), 6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
